// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: stage control fields in,
// pipeline register enables/flushes and debug counters out.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_uses_rs;
  logic        ID_uses_rt;
  logic        ID_Jump;
  logic        EX_MemRead;
  logic [4:0]  EX_Write_register;
  logic        EX_Branch_taken;
  logic        MEM_MemReq;
  logic        dmem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_flush;
  logic        exmem_write;
  logic        memwb_flush;
  logic        mem_wait;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_Jump,
    input  EX_MemRead, EX_Write_register, EX_Branch_taken,
    input  MEM_MemReq, dmem_ready,
    output pc_write, ifid_write, ifid_flush,
    output idex_write, idex_flush, exmem_write, memwb_flush,
    output mem_wait, mem_timeout, stall_cnt, flush_cnt
  );

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_Jump,
    output EX_MemRead, EX_Write_register, EX_Branch_taken,
    output MEM_MemReq, dmem_ready,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_write, idex_flush, exmem_write, memwb_flush,
    input  mem_wait, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline:
// load-use, taken branch/jump, and bounded memory wait.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] TMO  = 8'(MEM_TIMEOUT);

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  logic        load_use;
  logic        force_rel;
  logic        mem_stall;
  logic        pc_w, ifid_w, ifid_f;
  logic        idex_w, idex_f, exmem_w, memwb_f;
  logic        timeout_q;
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Hazard detection terms
  always_comb begin
    load_use = hz.EX_MemRead
      & (hz.EX_Write_register != 5'd0)
      & ((hz.ID_uses_rs & (hz.EX_Write_register == hz.ID_rs))
       | (hz.ID_uses_rt & (hz.EX_Write_register == hz.ID_rt)));
    force_rel = (state == WAIT) & (wait_cnt == TMO);
    mem_stall = hz.MEM_MemReq & ~hz.dmem_ready & ~force_rel;
  end

  // Prioritised pipeline register controls
  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    exmem_w = 1'b1;
    memwb_f = 1'b0;
    if (!reset) begin
      priority case (1'b1)
        mem_stall: begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          exmem_w = 1'b0;
          memwb_f = 1'b1;
        end
        hz.EX_Branch_taken: begin
          ifid_f = 1'b1;
          idex_f = 1'b1;
        end
        load_use: begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
        end
        hz.ID_Jump: ifid_f = 1'b1;
        default: ;
      endcase
    end
  end

  // Memory-wait FSM next state and wait counter
  always_comb begin
    state_nxt = state;
    wait_nxt  = 8'd0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = WAIT;
          wait_nxt  = 8'd1;
        end
      end
      default: begin
        if (mem_stall) wait_nxt = wait_cnt + 8'd1;
        else           state_nxt = RUN;
      end
    endcase
  end

  // FSM, timeout flag and saturating statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
      stall_q   <= 16'd0;
      flush_q   <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (force_rel) timeout_q <= 1'b1;
      if (!pc_w && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (ifid_f && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign hz.pc_write    = pc_w;
  assign hz.ifid_write  = ifid_w;
  assign hz.ifid_flush  = ifid_f;
  assign hz.idex_write  = idex_w;
  assign hz.idex_flush  = idex_f;
  assign hz.exmem_write = exmem_w;
  assign hz.memwb_flush = memwb_f;
  assign hz.mem_wait    = (state == WAIT);
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed
// vectors push expectations, a negedge monitor checks.
module tb_pipeline_hazard_ctrl;
  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] JMP = 7'b1111010;
  localparam logic [6:0] MS  = 7'b0000001;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [3:0] f;
    logic [4:0] ewr;
    logic [2:0] m;
  } stim_t;

  typedef struct {
    logic [6:0]  ctl;
    logic        mw;
    logic        mt;
    logic [15:0] sc;
    logic [15:0] fc;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] m_sc = 16'd0;
  logic [15:0] m_fc = 16'd0;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(
    logic [4:0] rs, logic [4:0] rt, logic [3:0] f,
    logic [4:0] ewr, logic [2:0] m);
    stim_t s;
    s.rs = rs; s.rt = rt; s.f = f; s.ewr = ewr; s.m = m;
    return s;
  endfunction

  // f = {uses_rs, uses_rt, jump, memread}
  // m = {branch_taken, mem_req, dmem_ready}
  task automatic cyc(input stim_t s, input logic rst,
                     input logic [6:0] ctl, input logic mw,
                     input logic mt, input logic chk,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    hz.ID_rs = s.rs;
    hz.ID_rt = s.rt;
    {hz.ID_uses_rs, hz.ID_uses_rt, hz.ID_Jump, hz.EX_MemRead} = s.f;
    hz.EX_Write_register = s.ewr;
    {hz.EX_Branch_taken, hz.MEM_MemReq, hz.dmem_ready} = s.m;
    if (rst) begin
      m_sc = 16'd0;
      m_fc = 16'd0;
    end
    if (chk) begin
      e.ctl = ctl; e.mw = mw; e.mt = mt;
      e.sc = m_sc; e.fc = m_fc; e.nm = nm;
      q.push_back(e);
    end
    if (!rst) begin
      if (!ctl[6] && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (ctl[4] && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
  endtask

  // Monitor: compare every presented cycle against the queue head
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {hz.pc_write, hz.ifid_write, hz.ifid_flush,
               hz.idex_write, hz.idex_flush, hz.exmem_write,
               hz.memwb_flush};
        checks++;
        if (act !== e.ctl || hz.mem_wait !== e.mw ||
            hz.mem_timeout !== e.mt || hz.stall_cnt !== e.sc ||
            hz.flush_cnt !== e.fc) begin
          errors++;
          $display("FAIL %s: got ctl=%b mw=%b mt=%b sc=%h fc=%h want ctl=%b mw=%b mt=%b sc=%h fc=%h",
                   e.nm, act, hz.mem_wait, hz.mem_timeout,
                   hz.stall_cnt, hz.flush_cnt, e.ctl, e.mw, e.mt,
                   e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    stim_t idle;
    idle = mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b000);
    hz.ID_rs = 5'd0; hz.ID_rt = 5'd0;
    hz.ID_uses_rs = 1'b0; hz.ID_uses_rt = 1'b0;
    hz.ID_Jump = 1'b0; hz.EX_MemRead = 1'b0;
    hz.EX_Write_register = 5'd0; hz.EX_Branch_taken = 1'b0;
    hz.MEM_MemReq = 1'b0; hz.dmem_ready = 1'b0;

    cyc(idle, 1'b1, DEF, 1'b0, 1'b0, 1'b1, "reset");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "idle");
    cyc(mk(5'd8, 5'd0, 4'b1001, 5'd8, 3'b000), 1'b0,
        LU, 1'b0, 1'b0, 1'b1, "lu_rs");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "lu_after");
    cyc(mk(5'd0, 5'd0, 4'b1001, 5'd0, 3'b000), 1'b0,
        DEF, 1'b0, 1'b0, 1'b1, "lu_r0");
    cyc(mk(5'd0, 5'd9, 4'b0101, 5'd9, 3'b000), 1'b0,
        LU, 1'b0, 1'b0, 1'b1, "lu_rt");
    cyc(mk(5'd0, 5'd9, 4'b0001, 5'd9, 3'b000), 1'b0,
        DEF, 1'b0, 1'b0, 1'b1, "lu_rt_unused");
    cyc(mk(5'd8, 5'd0, 4'b1001, 5'd8, 3'b100), 1'b0,
        BR, 1'b0, 1'b0, 1'b1, "br_over_lu");
    cyc(mk(5'd0, 5'd0, 4'b0010, 5'd0, 3'b000), 1'b0,
        JMP, 1'b0, 1'b0, 1'b1, "jump");
    cyc(mk(5'd8, 5'd0, 4'b1011, 5'd8, 3'b000), 1'b0,
        LU, 1'b0, 1'b0, 1'b1, "jump_lu");
    cyc(mk(5'd8, 5'd0, 4'b0010, 5'd0, 3'b000), 1'b0,
        JMP, 1'b0, 1'b0, 1'b1, "jump_deferred");
    cyc(mk(5'd0, 5'd0, 4'b0010, 5'd0, 3'b100), 1'b0,
        BR, 1'b0, 1'b0, 1'b1, "br_over_jump");

    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        MS, 1'b0, 1'b0, 1'b1, "mw_enter");
    cyc(mk(5'd8, 5'd0, 4'b1011, 5'd8, 3'b110), 1'b0,
        MS, 1'b1, 1'b0, 1'b1, "mw_over_br");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        MS, 1'b1, 1'b0, 1'b1, "mw_hold");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b011), 1'b0,
        DEF, 1'b1, 1'b0, 1'b1, "mw_ready");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "mw_run");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b011), 1'b0,
        DEF, 1'b0, 1'b0, 1'b1, "mem_fast");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "mem_fast_run");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        MS, 1'b0, 1'b0, 1'b1, "mw2_enter");
    cyc(idle, 1'b0, DEF, 1'b1, 1'b0, 1'b1, "mw2_noreq");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "mw2_run");

    for (int i = 0; i < 4; i++)
      cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
          MS, (i != 0), 1'b0, 1'b1, "to_stall");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        DEF, 1'b1, 1'b0, 1'b1, "to_release");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b1, 1'b1, "to_sticky");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b1, 1'b1, "to_sticky2");

    for (int i = 0; i < 70000; i++)
      cyc(mk(5'd8, 5'd0, 4'b1001, 5'd8, 3'b000), 1'b0,
          LU, 1'b0, 1'b1, 1'b0, "");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b1, 1'b1, "stall_sat");

    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        MS, 1'b0, 1'b1, 1'b1, "rw_enter");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        MS, 1'b1, 1'b1, 1'b1, "rw_wait");
    cyc(mk(5'd8, 5'd0, 4'b1001, 5'd8, 3'b010), 1'b1,
        DEF, 1'b0, 1'b0, 1'b1, "rw_reset");
    cyc(mk(5'd8, 5'd0, 4'b1001, 5'd8, 3'b010), 1'b1,
        DEF, 1'b0, 1'b0, 1'b1, "rw_reset_hold");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "rw_idle");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b010), 1'b0,
        MS, 1'b0, 1'b0, 1'b1, "rw2_enter");
    cyc(mk(5'd0, 5'd0, 4'b0000, 5'd0, 3'b011), 1'b0,
        DEF, 1'b1, 1'b0, 1'b1, "rw2_ready");
    cyc(idle, 1'b0, DEF, 1'b0, 1'b0, 1'b1, "rw2_run");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It watches the ID, EX and MEM stage control fields and drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- load-use data hazards;
- taken branches and jumps;
- multi-cycle data-memory accesses, with a bounded wait timeout.

It also keeps saturating stall and flush statistics counters for the debug display.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum number of consecutive memory-wait stall cycles before a forced release. Legal range is 1..255.

Ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- reset, in, 1: reset, asynchronous, active-high.
- ID_rs, in, 5: rs field of the instruction in ID.
- ID_rt, in, 5: rt field of the instruction in ID.
- ID_uses_rs, in, 1: the ID instruction reads rs.
- ID_uses_rt, in, 1: the ID instruction reads rt.
- ID_Jump, in, 1: the ID instruction is j/jal/jr/jalr (target resolved in ID).
- EX_MemRead, in, 1: the EX instruction is a load.
- EX_Write_register, in, 5: destination register of the EX instruction.
- EX_Branch_taken, in, 1: the EX instruction is a branch that resolved taken.
- MEM_MemReq, in, 1: the MEM instruction accesses data memory (read or write).
- dmem_ready, in, 1: data memory completes the access this cycle.
- pc_write, out, 1: PC load enable.
- ifid_write, out, 1: IF/ID load enable.
- ifid_flush, out, 1: IF/ID loads a bubble.
- idex_write, out, 1: ID/EX load enable.
- idex_flush, out, 1: ID/EX loads a bubble.
- exmem_write, out, 1: EX/MEM load enable.
- memwb_flush, out, 1: MEM/WB loads a bubble (RegWrite=0, MemRead=0).
- mem_wait, out, 1: the FSM is in the WAIT state.
- mem_timeout, out, 1: sticky flag; set when a forced release has occurred.
- stall_cnt, out, 16: number of cycles with pc_write=0; saturates at 16'hFFFF.
- flush_cnt, out, 16: number of cycles with ifid_flush=1; saturates at 16'hFFFF.

## Operation
Hazard terms:
- load_use = EX_MemRead & (EX_Write_register != 0) & ((ID_uses_rs & EX_Write_register == ID_rs) | (ID_uses_rt & EX_Write_register == ID_rt)).
- mem_stall = MEM_MemReq & ~dmem_ready & ~force_rel.
- force_rel = (state == WAIT) & (wait_cnt == MEM_TIMEOUT).

FSM states and transitions:
- RUN → WAIT when mem_stall.
- WAIT stays in WAIT while mem_stall.
- WAIT → RUN when dmem_ready, when ~MEM_MemReq, or when force_rel.

wait_cnt (8-bit):
- Loaded with 1 on RUN → WAIT.
- Increments each cycle the FSM stays in WAIT.
- Cleared when the FSM returns to RUN.

Control outputs are combinational from the current inputs and state. They are evaluated in strict priority order; the default is all *_write=1 and all *_flush=0.
1. mem_stall:
   - pc_write = ifid_write = idex_write = exmem_write = 0.
   - memwb_flush = 1.
   - Branch, jump and load-use actions are suppressed. EX/ID are held, so these hazards are re-evaluated after release.
2. EX_Branch_taken:
   - ifid_flush = 1, idex_flush = 1, pc_write = 1 (the PC takes the branch target).
   - A concurrent load_use is ignored because the ID instruction is wrong-path.
3. load_use:
   - pc_write = 0, ifid_write = 0, idex_flush = 1.
   - ID_Jump is deferred to the next cycle.
4. ID_Jump: ifid_flush = 1.

A flush takes precedence over a write in the target register: a register with flush=1 loads a bubble even though its write=1.

Counters:
- stall_cnt increments on every non-reset cycle with pc_write=0.
- flush_cnt increments on every non-reset cycle with ifid_flush=1.
- Both saturate and never wrap.

mem_timeout is set on any cycle with force_rel. It is cleared only by reset.

## Timing
- Control outputs have zero latency: they respond in the same cycle and act on the next clk edge.
- The FSM, wait_cnt, counters and mem_timeout update on the rising edge of clk.
- Reset (asynchronous) forces:
  - state = RUN, wait_cnt = 0, stall_cnt = 0, flush_cnt = 0;
  - mem_wait = 0, mem_timeout = 0;
  - control outputs to their default (all *_write=1, all *_flush=0) while reset is high.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs 2 flushed slots. A jump costs 1 flushed slot.
- A memory wait stalls for at most MEM_TIMEOUT consecutive cycles. On the cycle after that, the pipeline advances even with dmem_ready=0.
- dmem_ready in the same cycle as MEM_MemReq rising gives no stall and no WAIT entry.
- Reset asserted in WAIT:
  - returns the FSM to RUN immediately;
  - clears mem_timeout;
  - gives no forced-release side effects.

## Test plan
- Load-use: lw $8 in EX (EX_MemRead=1, EX_Write_register=8) with ID_rs=8, ID_uses_rs=1 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt goes 0→1; the next cycle is default. Repeat with EX_Write_register=0 → no stall.
- Branch over load-use: EX_Branch_taken=1 together with a load_use match → ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt increments by 1.
- Memory wait: MEM_MemReq=1 with dmem_ready low for 3 cycles, then high → 3 cycles of all writes 0 and memwb_flush=1, mem_wait=1 on the 3 cycles after entry, then RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4 with dmem_ready held 0 → 4 stall cycles, then 1 advance cycle; mem_timeout=1 and stays 1 until reset.
- Jump deferral: ID_Jump=1 together with load_use → stall cycle first with ifid_flush=0, then ifid_flush=1 the next cycle.
- Saturation and reset: preload by holding a load-use for 70000 cycles → stall_cnt=16'hFFFF. Assert reset mid-WAIT → all counters 0, mem_wait=0, outputs at default.
